// File: rtl/ram_port_adapter.sv
// ram_port_adapter: request/response front-end for one port of the simulation
// dual-port byte RAM. Requests are buffered in a small FIFO, issued to the RAM
// port one per cycle, tagged while the RAM's 1-cycle registered read is in
// flight, then captured into an in-order response buffer with backpressure.
//
// Optional build macro: RAM_ADAPTER_BYPASS_EN
//   When defined, a request accepted while the request FIFO is empty and the
//   response side has room issues in the same cycle, skipping the FIFO and
//   saving one cycle of latency.
//
// Handshake semantics (both req_* and rsp_* channels): a transfer happens on
// the rising clk edge where valid and ready are both high. Once valid is high
// the payload is held stable until that transfer. req_ready_o depends only on
// registered FIFO occupancy, never on a same-cycle pop.
module ram_port_adapter #(
    parameter int unsigned MEM_WIDTH = 65536,
    parameter int unsigned REQ_DEPTH = 2,
    parameter int unsigned RSP_DEPTH = 2,
    localparam int unsigned AW = $clog2(MEM_WIDTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [31:0]   req_addr_i,
    input  logic [3:0]    req_we_i,
    input  logic [31:0]   req_data_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_data_o,
    output logic          rsp_err_o,
    output logic          mem_en_o,
    output logic [3:0]    mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_data_o,
    input  logic [31:0]   mem_data_i
);

    localparam int unsigned RPW  = $clog2(REQ_DEPTH);
    localparam int unsigned RCW  = $clog2(REQ_DEPTH + 1);
    localparam int unsigned SPW  = $clog2(RSP_DEPTH);
    localparam int unsigned SCW  = $clog2(RSP_DEPTH + 1);
    localparam int unsigned OCCW = SCW + 1;

    // Highest legal start address: the RAM touches addr..addr+3.
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_WIDTH - 4);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    we;
        logic [31:0]   data;
        logic          err;
    } req_t;

    // ------------------------------------------------------------------
    // Request FIFO state
    // ------------------------------------------------------------------
    req_t           req_mem [REQ_DEPTH];
    logic [RPW-1:0] req_wr_ptr;
    logic [RPW-1:0] req_rd_ptr;
    logic [RCW-1:0] req_count;
    logic           req_empty;

    // ------------------------------------------------------------------
    // In-flight tag (one RAM access outstanding at most per cycle)
    // ------------------------------------------------------------------
    logic inflight;
    logic infl_write;
    logic infl_err;

    // ------------------------------------------------------------------
    // Response buffer state
    // ------------------------------------------------------------------
    logic [31:0]    rsp_data_mem [RSP_DEPTH];
    logic           rsp_err_mem  [RSP_DEPTH];
    logic [SPW-1:0] rsp_wr_ptr;
    logic [SPW-1:0] rsp_rd_ptr;
    logic [SCW-1:0] rsp_count;

    // ------------------------------------------------------------------
    // Datapath / control nets
    // ------------------------------------------------------------------
    req_t            in_req;
    req_t            head;
    logic            rsp_pop;
    logic [OCCW-1:0] rsp_occ;
    logic            space_ok;
    logic            use_bypass;
    logic            fifo_push;
    logic            fifo_pop;
    logic            issue;
    logic            mem_fire;
    logic            rsp_push;
    logic [31:0]     rsp_in_data;
    logic            rsp_in_err;

    assign req_empty   = (req_count == '0);
    assign req_ready_o = (req_count != RCW'(REQ_DEPTH));
    assign rsp_valid_o = (rsp_count != '0);
    assign rsp_data_o  = rsp_data_mem[rsp_rd_ptr];
    assign rsp_err_o   = rsp_err_mem[rsp_rd_ptr];

    // Incoming request entry, including the range check done at push time.
    always_comb begin
        in_req      = '0;
        in_req.addr = req_addr_i[AW-1:0];
        in_req.we   = req_we_i;
        in_req.data = req_data_i;
        in_req.err  = (|req_addr_i[31:AW]) | (req_addr_i[AW-1:0] > LAST_ADDR);
    end

    // Issue decision: issue only when the response side can absorb the result.
    always_comb begin
        rsp_pop  = rsp_valid_o & rsp_ready_i;
        rsp_occ  = {1'b0, rsp_count} + OCCW'(inflight) - OCCW'(rsp_pop);
        space_ok = (rsp_occ < OCCW'(RSP_DEPTH));
`ifdef RAM_ADAPTER_BYPASS_EN
        use_bypass = req_empty & req_valid_i & space_ok;
`else
        use_bypass = 1'b0;
`endif
        fifo_pop  = ~req_empty & space_ok;
        fifo_push = req_valid_i & req_ready_o & ~use_bypass;
        issue     = fifo_pop | use_bypass;
        head      = use_bypass ? in_req : req_mem[req_rd_ptr];
    end

    // RAM port drive: quiet (all zero) unless a non-error request issues.
    always_comb begin
        mem_fire   = issue & ~head.err;
        mem_en_o   = mem_fire;
        mem_we_o   = mem_fire ? head.we   : '0;
        mem_addr_o = mem_fire ? head.addr : '0;
        mem_data_o = mem_fire ? head.data : '0;
    end

    // Capture path: result of last cycle's issue enters the response buffer.
    always_comb begin
        rsp_push    = inflight;
        rsp_in_err  = infl_err;
        rsp_in_data = (infl_err | infl_write) ? 32'h0 : mem_data_i;
    end

    // Request FIFO payload storage (no reset needed; gated by count).
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            req_mem[req_wr_ptr] <= in_req;
        end
    end

    // Request FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_wr_ptr <= '0;
            req_rd_ptr <= '0;
            req_count  <= '0;
        end else begin
            if (fifo_push) begin
                req_wr_ptr <= req_wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                req_rd_ptr <= req_rd_ptr + 1'b1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   req_count <= req_count + 1'b1;
                2'b01:   req_count <= req_count - 1'b1;
                default: req_count <= req_count;
            endcase
        end
    end

    // In-flight tag: set by an issue, cleared the cycle after unless reissued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight   <= 1'b0;
            infl_write <= 1'b0;
            infl_err   <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                infl_write <= |head.we;
                infl_err   <= head.err;
            end
        end
    end

    // Response buffer storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(RSP_DEPTH); i++) begin
                rsp_data_mem[i] <= '0;
                rsp_err_mem[i]  <= 1'b0;
            end
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_count  <= '0;
        end else begin
            if (rsp_push) begin
                rsp_data_mem[rsp_wr_ptr] <= rsp_in_data;
                rsp_err_mem[rsp_wr_ptr]  <= rsp_in_err;
                rsp_wr_ptr               <= rsp_wr_ptr + 1'b1;
            end
            if (rsp_pop) begin
                rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
            end
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_count <= rsp_count + 1'b1;
                2'b01:   rsp_count <= rsp_count - 1'b1;
                default: rsp_count <= rsp_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_adapter.sv
// tb_ram_port_adapter: directed bench for ram_port_adapter with a byte RAM
// model behind the port and an in-order expected-response queue.
module tb_ram_port_adapter;

`ifdef RAM_ADAPTER_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [3:0]  req_we_i;
    logic [31:0] req_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    ram_port_adapter #(
        .MEM_WIDTH(65536),
        .REQ_DEPTH(2),
        .RSP_DEPTH(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_addr_i (req_addr_i),
        .req_we_i   (req_we_i),
        .req_data_i (req_data_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_data_o (rsp_data_o),
        .rsp_err_o  (rsp_err_o),
        .mem_en_o   (mem_en_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;
    int en_cnt = 0;
    int run = 0;
    int max_run = 0;
    logic popped_prev = 1'b0;
    logic hold_prev = 1'b0;
    logic [63:0] hold_val = '0;

    logic [32:0] exp_q[$];          // {err, data}
    logic [7:0]  shadow [0:65535];  // bench's own view of RAM contents
    logic [7:0]  ram    [0:65535];  // RAM model behind the port

    function automatic logic [7:0] pat(input int i);
        logic [7:0] v;
        v = 8'(i * 7 + (i >> 8) + 3);
        if (i == 32'h100) v = 8'h11;
        if (i == 32'h101) v = 8'h22;
        if (i == 32'h102) v = 8'h33;
        if (i == 32'h103) v = 8'h44;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- RAM model (registered read) ----------------
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = pat(i);
        mem_data_i = '0;
    end

    always @(posedge clk) begin
        if (mem_en_o) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_we_o[i]) ram[32'(mem_addr_o) + i] <= mem_data_o[8*i +: 8];
            end
            mem_data_i <= {ram[32'(mem_addr_o) + 3], ram[32'(mem_addr_o) + 2],
                           ram[32'(mem_addr_o) + 1], ram[32'(mem_addr_o)]};
        end
    end

    // ---------------- response monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [32:0] e;
        if (mem_en_o) en_cnt++;
        if (reset_n) begin
            if (hold_prev) begin
                chk("rsp_hold_stable", 64'({rsp_valid_o, rsp_err_o, rsp_data_o}), hold_val);
            end
            if (rsp_valid_o && rsp_ready_i) begin
                pop_cnt++;
                run = popped_prev ? run + 1 : 1;
                if (run > max_run) max_run = run;
                if (exp_q.size() == 0) begin
                    chk("rsp_expected_pending", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_err", 64'(rsp_err_o), 64'(e[32]));
                    chk("rsp_data", 64'(rsp_data_o), 64'(e[31:0]));
                end
            end
            popped_prev = rsp_valid_o & rsp_ready_i;
            hold_prev   = rsp_valid_o & ~rsp_ready_i;
            hold_val    = 64'({rsp_valid_o, rsp_err_o, rsp_data_o});
        end else begin
            popped_prev = 1'b0;
            hold_prev   = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
        int w;
        int a;
        logic err;
        err = (addr[31:16] != 16'h0) || (addr[15:0] > 16'hFFFC);
        a = int'(addr[15:0]);
        if (err) begin
            exp_q.push_back({1'b1, 32'h0});
        end else if (we != 4'h0) begin
            for (int i = 0; i < 4; i++) if (we[i]) shadow[a + i] = data[8*i +: 8];
            exp_q.push_back({1'b0, 32'h0});
        end else begin
            exp_q.push_back({1'b0, shadow[a + 3], shadow[a + 2], shadow[a + 1], shadow[a]});
        end
        req_addr_i  = addr;
        req_we_i    = we;
        req_data_i  = data;
        req_valid_i = 1'b1;
        w = 0;
        @(negedge clk);
        while (!req_ready_o && w < 200) begin
            w++;
            stall_cnt++;
            @(negedge clk);
        end
        if (!req_ready_o) begin
            chk("req_accept_timeout", 64'(req_ready_o), 64'd1);
            req_valid_i = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc_cnt++;
        end
    endtask

    task automatic idle();
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_we_i    = '0;
        req_data_i  = '0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            w++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int en0;
        int pop0;
        for (int i = 0; i < 65536; i++) shadow[i] = pat(i);

        // reset
        reset_n     = 1'b0;
        rsp_ready_i = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready_o), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data_o), 64'd0);
        chk("reset_rsp_err", 64'(rsp_err_o), 64'd0);
        chk("reset_mem_en", 64'(mem_en_o), 64'd0);
        chk("reset_mem_we", 64'(mem_we_o), 64'd0);
        chk("reset_mem_addr", 64'(mem_addr_o), 64'd0);
        chk("reset_mem_data", 64'(mem_data_o), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // single read, latency
        @(posedge clk);
        #1;
        send(32'h100, 4'h0, 32'h0);
        idle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lat_rsp_valid", 64'(rsp_valid_o), 64'(k == LAT));
            if (k == LAT) chk("read_0x100", 64'(rsp_data_o), 64'h44332211);
        end
        drain();

        // partial write then read back
        @(posedge clk);
        #1;
        send(32'h200, 4'b0011, 32'hAABBCCDD);
        send(32'h200, 4'h0, 32'h0);
        idle();
        drain();
        chk("ram_byte_0x200", 64'(ram[32'h200]), 64'hDD);
        chk("ram_byte_0x202_kept", 64'(ram[32'h202]), 64'(pat(32'h202)));

        // out-of-range requests interleaved with a valid one
        en0 = en_cnt;
        @(posedge clk);
        #1;
        send(32'h0001_0000, 4'h0, 32'h0);
        send(32'h0000_FFFD, 4'h0, 32'h0);
        send(32'h0000_FFFC, 4'h0, 32'h0);
        idle();
        drain();
        chk("err_no_mem_en", 64'(en_cnt - en0), 64'd1);

        // back-to-back reads at full rate
        stall_cnt = 0;
        max_run   = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send(32'($urandom_range(0, 16'h3FFF)) << 2, 4'h0, 32'h0);
        idle();
        drain();
        chk("b2b_no_stall", 64'(stall_cnt), 64'd0);
        chk("b2b_consecutive", 64'(max_run), 64'd8);

        // backpressure: fill, then release
        pop0    = pop_cnt;
        acc_cnt = 0;
        @(posedge clk);
        #1 rsp_ready_i = 1'b0;
        fork
            begin
                repeat (30) @(negedge clk);
                chk("fill_req_ready_low", 64'(req_ready_o), 64'd0);
                chk("fill_accepted", 64'(acc_cnt), 64'd4);
                chk("fill_rsp_valid", 64'(rsp_valid_o), 64'd1);
                @(posedge clk);
                #1 rsp_ready_i = 1'b1;
            end
        join_none
        for (int i = 0; i < 6; i++) send(32'($urandom_range(0, 16'h3FFF)) << 2, 4'h0, 32'h0);
        idle();
        drain();
        chk("fill_all_returned", 64'(pop_cnt - pop0), 64'd6);

        // reset while a read is in flight
        @(posedge clk);
        #1;
        send(32'h104, 4'h0, 32'h0);
        idle();
`ifndef RAM_ADAPTER_BYPASS_EN
        @(posedge clk);
        #1;
`endif
        pop0    = pop_cnt;
        reset_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
            chk("post_reset_req_ready", 64'(req_ready_o), 64'd1);
        end
        chk("post_reset_no_stale", 64'(pop_cnt - pop0), 64'd0);

        // adapter still works after the mid-flight reset
        @(posedge clk);
        #1;
        send(32'h100, 4'h0, 32'h0);
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
